// File: rtl/vector_exec_pkg.sv
// Shared types and defaults for the vector execute stage.
package vector_exec_pkg;

   localparam int unsigned LANE_W_DEF    = 8;
   localparam int unsigned NUM_LANES_DEF = 16;
   localparam int unsigned VEC_W         = 128;
   localparam int unsigned REG_IDX_W     = 4;

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001,
      OpAnd = 3'b010,
      OpOr  = 3'b011,
      OpXor = 3'b100,
      OpMul = 3'b101,
      OpShl = 3'b110,
      OpShr = 3'b111
   } vec_op_e;

   typedef enum logic [1:0] {
      StateIdle = 2'd0,
      StateExec = 2'd1,
      StateWb   = 2'd2
   } exec_state_e;

endpackage

// File: rtl/vector_exec_unit_if.sv
// Issue-side handshake plus register-file write port of the vector execute stage.
interface vector_exec_unit_if;
   import vector_exec_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           op;
   logic [VEC_W-1:0]     src_a;
   logic [VEC_W-1:0]     src_b;
   logic [REG_IDX_W-1:0] dst;
   logic                 wre;
   logic [REG_IDX_W-1:0] a3;
   logic [VEC_W-1:0]     wd3;
   logic                 busy;

   modport master (
      output in_valid, op, src_a, src_b, dst,
      input  in_ready, wre, a3, wd3, busy
   );

   modport slave (
      input  in_valid, op, src_a, src_b, dst,
      output in_ready, wre, a3, wd3, busy
   );

endinterface

// File: rtl/vector_lane_alu.sv
// Combinational single-lane ALU. Defining VEC_EXEC_SAT_EN makes ADD/MUL saturate and
// SUB clamp at zero; otherwise all arithmetic wraps.
module vector_lane_alu
   import vector_exec_pkg::*;
#(
   parameter int unsigned LANE_W = LANE_W_DEF
) (
   input  vec_op_e           op,
   input  logic [LANE_W-1:0] a,
   input  logic [LANE_W-1:0] b,
   output logic [LANE_W-1:0] y
);

   localparam int unsigned ShW = $clog2(LANE_W);

   logic [ShW-1:0] sh;
   assign sh = b[ShW-1:0];

`ifdef VEC_EXEC_SAT_EN
   logic [LANE_W:0]     sum;
   logic [2*LANE_W-1:0] prod;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
`endif

   always_comb begin
      y = '0;
      unique case (op)
`ifdef VEC_EXEC_SAT_EN
         OpAdd: y = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
         OpSub: y = (a < b) ? '0 : a - b;
         OpMul: y = (|prod[2*LANE_W-1:LANE_W]) ? '1 : prod[LANE_W-1:0];
`else
         OpAdd: y = a + b;
         OpSub: y = a - b;
         OpMul: y = a * b;
`endif
         OpAnd: y = a & b;
         OpOr:  y = a | b;
         OpXor: y = a ^ b;
         OpShl: y = a << sh;
         OpShr: y = a >> sh;
      endcase
   end

endmodule

// File: rtl/vector_exec_unit.sv
// Vector execute stage: captures one operation, computes LANES_PER_CYCLE lanes per cycle,
// then issues a single-cycle register-file write. Lane saturation via VEC_EXEC_SAT_EN.
module vector_exec_unit
   import vector_exec_pkg::*;
#(
   parameter int unsigned LANE_W          = LANE_W_DEF,
   parameter int unsigned NUM_LANES       = NUM_LANES_DEF,
   parameter int unsigned LANES_PER_CYCLE = 4
) (
   input logic               clk,
   input logic               rst,
   vector_exec_unit_if.slave bus
);

   localparam int unsigned NumChunks = NUM_LANES / LANES_PER_CYCLE;
   localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

   localparam logic [1:0] StIdle = StateIdle;
   localparam logic [1:0] StExec = StateExec;
   localparam logic [1:0] StWb   = StateWb;

   if (NUM_LANES % LANES_PER_CYCLE != 0) begin : g_bad_split
      $error("LANES_PER_CYCLE must divide NUM_LANES");
   end
   if (LANE_W * NUM_LANES != VEC_W) begin : g_bad_width
      $error("LANE_W * NUM_LANES must equal VEC_W");
   end

   logic [1:0]           state_q, state_d;
   logic [ChunkW-1:0]    chunk_q;
   vec_op_e              op_q;
   logic [VEC_W-1:0]     a_q, b_q, res_q, res_upd;
   logic [REG_IDX_W-1:0] dst_q, a3_q;
   logic [VEC_W-1:0]     wd3_q;
   logic                 last_chunk;

   logic [LANE_W-1:0] lane_a [LANES_PER_CYCLE];
   logic [LANE_W-1:0] lane_b [LANES_PER_CYCLE];
   logic [LANE_W-1:0] lane_y [LANES_PER_CYCLE];

   assign last_chunk = (chunk_q == LastChunk);

   for (genvar l = 0; l < LANES_PER_CYCLE; l++) begin : g_lane
      assign lane_a[l] = a_q[(int'(chunk_q) * LANES_PER_CYCLE + l) * LANE_W +: LANE_W];
      assign lane_b[l] = b_q[(int'(chunk_q) * LANES_PER_CYCLE + l) * LANE_W +: LANE_W];

      vector_lane_alu #(
         .LANE_W (LANE_W)
      ) u_alu (
         .op (op_q),
         .a  (lane_a[l]),
         .b  (lane_b[l]),
         .y  (lane_y[l])
      );
   end

   // Merge this cycle's lanes into the partial result.
   always_comb begin
      res_upd = res_q;
      for (int l = 0; l < LANES_PER_CYCLE; l++) begin
         res_upd[(int'(chunk_q) * LANES_PER_CYCLE + l) * LANE_W +: LANE_W] = lane_y[l];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.in_valid) state_d = StExec;
         StExec:  if (last_chunk) state_d = StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         chunk_q <= '0;
         op_q    <= OpAdd;
         a_q     <= '0;
         b_q     <= '0;
         dst_q   <= '0;
         res_q   <= '0;
         a3_q    <= '0;
         wd3_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && bus.in_valid) begin
            op_q    <= vec_op_e'(bus.op);
            a_q     <= bus.src_a;
            b_q     <= bus.src_b;
            dst_q   <= bus.dst;
            res_q   <= '0;
            chunk_q <= '0;
         end else if (state_q == StExec) begin
            res_q   <= res_upd;
            chunk_q <= last_chunk ? '0 : chunk_q + 1'b1;
            // Write-port registers only change on the way into WB so they hold otherwise.
            if (last_chunk) begin
               a3_q  <= dst_q;
               wd3_q <= res_upd;
            end
         end
      end
   end

   assign bus.in_ready = (state_q == StIdle);
   assign bus.busy     = (state_q != StIdle);
   assign bus.wre      = (state_q == StWb);
   assign bus.a3       = a3_q;
   assign bus.wd3      = wd3_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed self-checking bench for vector_exec_unit.
module tb_vector_exec_unit;
   import vector_exec_pkg::*;

`ifdef VEC_EXEC_SAT_EN
   localparam logic [7:0] EXP_ADD_OVF = 8'hFF;
   localparam logic [7:0] EXP_SUB_UNF = 8'h00;
   localparam logic [7:0] EXP_MUL_OVF = 8'hFF;
`else
   localparam logic [7:0] EXP_ADD_OVF = 8'h01;
   localparam logic [7:0] EXP_SUB_UNF = 8'hFF;
   localparam logic [7:0] EXP_MUL_OVF = 8'h00;
`endif

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   vector_exec_unit_if bus ();

   vector_exec_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offers one op, scrambles the sources after the accept edge, and waits for wre.
   // lat counts samples after the accept edge until wre is seen (-1 if never).
   task automatic issue_op(input logic [2:0] o, input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] a_after, input logic [3:0] d,
                           output int lat, output logic [127:0] data, output logic [3:0] addr,
                           output logic wre_next, output logic rdy_next,
                           output logic [127:0] wd3_next);
      @(negedge clk);
      bus.op       = o;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.dst      = d;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.src_a    = a_after;
      bus.src_b    = ~b;
      lat  = -1;
      data = '0;
      addr = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.wre) begin
            lat  = k;
            data = bus.wd3;
            addr = bus.a3;
            break;
         end
      end
      @(posedge clk);
      #1;
      wre_next = bus.wre;
      rdy_next = bus.in_ready;
      wd3_next = bus.wd3;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (bus.wre !== 1'b0) $display("FAIL reset_wre got %b want 0", bus.wre);
      else n_pass++;
      n_total++; if (bus.a3 !== 4'h0) $display("FAIL reset_a3 got %h want 0", bus.a3);
      else n_pass++;
      n_total++; if (bus.wd3 !== 128'h0) $display("FAIL reset_wd3 got %h want 0", bus.wd3);
      else n_pass++;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_wrap();
      int lat; logic [127:0] data, wn; logic [3:0] addr; logic we, rd;
      issue_op(OpAdd, {16{8'h10}}, {16{8'h05}}, {16{8'h10}}, 4'd5, lat, data, addr, we, rd, wn);
      n_total++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat);
      else n_pass++;
      n_total++; if (data !== {16{8'h15}}) $display("FAIL add_data got %h want %h", data,
                                                     {16{8'h15}});
      else n_pass++;
      n_total++; if (addr !== 4'd5) $display("FAIL add_a3 got %0d want 5", addr);
      else n_pass++;
      n_total++; if (we !== 1'b0) $display("FAIL add_wre_single got %b want 0", we);
      else n_pass++;
      n_total++; if (rd !== 1'b1) $display("FAIL add_ready_after got %b want 1", rd);
      else n_pass++;
      n_total++; if (wn !== {16{8'h15}}) $display("FAIL add_wd3_hold got %h want %h", wn,
                                                   {16{8'h15}});
      else n_pass++;
      issue_op(OpAdd, {16{8'hFF}}, {16{8'h02}}, {16{8'hFF}}, 4'd6, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{EXP_ADD_OVF}}) $display("FAIL add_ovf got %h want %h", data,
                                                           {16{EXP_ADD_OVF}});
      else n_pass++;
      n_total++; if (addr !== 4'd6) $display("FAIL add_ovf_a3 got %0d want 6", addr);
      else n_pass++;
   endtask

   task automatic test_sub_underflow();
      int lat; logic [127:0] data, wn; logic [3:0] addr; logic we, rd;
      issue_op(OpSub, {16{8'h00}}, {16{8'h01}}, {16{8'h00}}, 4'd1, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{EXP_SUB_UNF}}) $display("FAIL sub_unf got %h want %h", data,
                                                           {16{EXP_SUB_UNF}});
      else n_pass++;
      issue_op(OpSub, {16{8'h30}}, {16{8'h12}}, {16{8'h30}}, 4'd2, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{8'h1E}}) $display("FAIL sub_plain got %h want %h", data,
                                                     {16{8'h1E}});
      else n_pass++;
   endtask

   task automatic test_mul_shift();
      int lat; logic [127:0] data, wn; logic [3:0] addr; logic we, rd;
      issue_op(OpMul, {16{8'h0F}}, {16{8'h03}}, {16{8'h0F}}, 4'd2, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{8'h2D}}) $display("FAIL mul got %h want %h", data,
                                                     {16{8'h2D}});
      else n_pass++;
      issue_op(OpMul, {16{8'h10}}, {16{8'h10}}, {16{8'h10}}, 4'd3, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{EXP_MUL_OVF}}) $display("FAIL mul_ovf got %h want %h", data,
                                                           {16{EXP_MUL_OVF}});
      else n_pass++;
      issue_op(OpShl, {16{8'h81}}, {16{8'h09}}, {16{8'h81}}, 4'd4, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{8'h02}}) $display("FAIL shl got %h want %h", data,
                                                     {16{8'h02}});
      else n_pass++;
      issue_op(OpShr, {16{8'h80}}, {16{8'h07}}, {16{8'h80}}, 4'd8, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{8'h01}}) $display("FAIL shr got %h want %h", data,
                                                     {16{8'h01}});
      else n_pass++;
      issue_op(OpXor, {16{8'hF0}}, {16{8'h3C}}, {16{8'hF0}}, 4'd9, lat, data, addr, we, rd, wn);
      n_total++; if (data !== {16{8'hCC}}) $display("FAIL xor got %h want %h", data,
                                                     {16{8'hCC}});
      else n_pass++;
   endtask

   task automatic test_lanes();
      int lat; logic [127:0] data, wn, a, exp; logic [3:0] addr; logic we, rd;
      for (int i = 0; i < 16; i++) begin
         a[i*8 +: 8]   = 8'(i);
         exp[i*8 +: 8] = 8'(i + 1);
      end
      issue_op(OpAdd, a, {16{8'h01}}, {128{1'b1}}, 4'd11, lat, data, addr, we, rd, wn);
      n_total++; if (data !== exp) $display("FAIL lanes got %h want %h", data, exp);
      else n_pass++;
      n_total++; if (addr !== 4'd11) $display("FAIL lanes_a3 got %0d want 11", addr);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int np, viol, consec, idx[4];
      logic [3:0] adr[4];
      logic prev_we, drained;
      logic [3:0] drain_adr;
      np = 0; viol = 0; consec = 0; prev_we = 1'b0;
      @(negedge clk);
      bus.op = OpAdd; bus.src_a = {16{8'h01}}; bus.src_b = {16{8'h01}};
      bus.dst = 4'd3; bus.in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.in_ready !== !bus.busy) viol++;
         if (bus.wre && prev_we) consec++;
         if (bus.wre) begin
            if (np < 4) begin idx[np] = k; adr[np] = bus.a3; end
            np++;
         end
         prev_we = bus.wre;
         if (k == 9) bus.dst = 4'd7;
      end
      bus.in_valid = 1'b0;
      drained = 1'b0; drain_adr = '0;
      for (int k = 0; k < 12 && !drained; k++) begin
         @(posedge clk);
         #1;
         if (bus.wre) begin drained = 1'b1; drain_adr = bus.a3; end
      end
      @(posedge clk);
      #1;
      n_total++; if (np !== 3) $display("FAIL b2b_pulses got %0d want 3", np);
      else n_pass++;
      n_total++; if (np >= 3 && {idx[0], idx[1], idx[2]} !== {32'd4, 32'd10, 32'd16})
         $display("FAIL b2b_timing got %0d,%0d,%0d want 4,10,16", idx[0], idx[1], idx[2]);
      else n_pass++;
      n_total++; if (np >= 3 && {adr[0], adr[1], adr[2]} !== {4'd3, 4'd3, 4'd7})
         $display("FAIL b2b_addr got %0d,%0d,%0d want 3,3,7", adr[0], adr[1], adr[2]);
      else n_pass++;
      n_total++; if (viol !== 0) $display("FAIL b2b_ready_busy got %0d want 0", viol);
      else n_pass++;
      n_total++; if (consec !== 0) $display("FAIL b2b_consec_wre got %0d want 0", consec);
      else n_pass++;
      n_total++; if (drained !== 1'b1 || drain_adr !== 4'd7)
         $display("FAIL b2b_drain got %b/%0d want 1/7", drained, drain_adr);
      else n_pass++;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_idle got %b want 1", bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [127:0] data, wn; logic [3:0] addr; logic we, rd, seen;
      @(negedge clk);
      bus.op = OpAdd; bus.src_a = {16{8'h22}}; bus.src_b = {16{8'h11}};
      bus.dst = 4'd9; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_total++; if (bus.wre !== 1'b0) $display("FAIL mid_rst_wre got %b want 0", bus.wre);
      else n_pass++;
      n_total++; if (bus.a3 !== 4'h0) $display("FAIL mid_rst_a3 got %h want 0", bus.a3);
      else n_pass++;
      n_total++; if (bus.wd3 !== 128'h0) $display("FAIL mid_rst_wd3 got %h want 0", bus.wd3);
      else n_pass++;
      n_total++;
      if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", bus.in_ready);
      else n_pass++;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.wre) seen = 1'b1;
      end
      n_total++; if (seen !== 1'b0) $display("FAIL mid_rst_no_write got %b want 0", seen);
      else n_pass++;
      issue_op(OpAdd, {16{8'h22}}, {16{8'h11}}, {16{8'h22}}, 4'd12, lat, data, addr, we, rd, wn);
      n_total++; if (lat !== 4) $display("FAIL post_rst_latency got %0d want 4", lat);
      else n_pass++;
      n_total++; if (data !== {16{8'h33}} || addr !== 4'd12)
         $display("FAIL post_rst_write got %h/%0d want %h/12", data, addr, {16{8'h33}});
      else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0;
      test_reset();
      test_add_wrap();
      test_sub_underflow();
      test_mul_shift();
      test_lanes();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
